// File: rtl/xor_neuro_sched.sv
// rtl/xor_neuro_sched.sv - time-shared neuron sequencer for the 2-2-1 XOR network
// Drives one pipelined neuron lane through 8 hidden-layer and 4 output-layer
// evaluations for a batch of four input pairs.
// Optional feature macro: XOR_SCHED_PERF_EN (adds the perf_runs run counter).
module xor_neuro_sched #(
  parameter int tam  = 16,
  parameter int NLAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0][tam-1:0] in1,
  input  logic [3:0][tam-1:0] in2,
  output logic                busy,
  output logic                done,
  output logic [3:0][tam-1:0] result,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [tam-1:0]      cfg_data,
  output logic                nrn_valid,
  output logic [tam-1:0]      nrn_in1,
  output logic [tam-1:0]      nrn_in2,
  output logic [tam-1:0]      nrn_w0,
  output logic [tam-1:0]      nrn_w1,
  output logic [tam-1:0]      nrn_w2,
  input  logic [tam-1:0]      nrn_result
`ifdef XOR_SCHED_PERF_EN
  ,
  output logic [15:0]         perf_runs
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L1     = 3'd1,
    S_DRAIN1 = 3'd2,
    S_L2     = 3'd3,
    S_DRAIN2 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Travels alongside each issue so the returning result knows where it belongs.
  typedef struct packed {
    logic       valid;
    logic       layer;
    logic [2:0] slot;
  } tag_t;

  state_t state_q, state_d;

  logic [2:0]           slot_q, slot_d;
  logic [8:0][tam-1:0]  wcfg_q, wcfg_d;    // host-visible weight file
  logic [8:0][tam-1:0]  wrun_q, wrun_d;    // weights frozen for the current run
  logic [3:0][tam-1:0]  in1_q, in1_d;
  logic [3:0][tam-1:0]  in2_q, in2_d;
  logic [3:0][tam-1:0]  z1_q, z1_d;
  logic [3:0][tam-1:0]  z2_q, z2_d;
  logic [3:0][tam-1:0]  shadow_q, shadow_d;
  logic [3:0][tam-1:0]  result_q, result_d;
  tag_t                 tag_q [NLAT];
  tag_t                 tag_d [NLAT];
  tag_t                 issue_tag;
  tag_t                 cap;
  logic                 cap_l1_last;
  logic                 cap_l2_last;

  // Oldest tag lines up with the nrn_result currently presented by the lane.
  assign cap         = tag_q[NLAT-1];
  assign cap_l1_last = cap.valid && !cap.layer && (cap.slot == 3'd7);
  assign cap_l2_last = cap.valid &&  cap.layer && (cap.slot == 3'd3);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: issue phases are slot-counted, drain phases wait on tags
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_L1;
      S_L1:     if (slot_q == 3'd7) state_d = S_DRAIN1;
      S_DRAIN1: if (cap_l1_last) state_d = S_L2;
      S_L2:     if (slot_q == 3'd3) state_d = S_DRAIN2;
      S_DRAIN2: if (cap_l2_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: operand routing to the neuron lane, zero when not issuing
  always_comb begin
    nrn_valid = 1'b0;
    nrn_in1   = '0;
    nrn_in2   = '0;
    nrn_w0    = '0;
    nrn_w1    = '0;
    nrn_w2    = '0;
    issue_tag = '0;
    case (state_q)
      S_L1: begin
        nrn_valid = 1'b1;
        nrn_in1   = in1_q[slot_q[2:1]];
        nrn_in2   = in2_q[slot_q[2:1]];
        if (slot_q[0]) begin
          nrn_w0 = wrun_q[3];
          nrn_w1 = wrun_q[4];
          nrn_w2 = wrun_q[5];
        end else begin
          nrn_w0 = wrun_q[0];
          nrn_w1 = wrun_q[1];
          nrn_w2 = wrun_q[2];
        end
        issue_tag = '{valid: 1'b1, layer: 1'b0, slot: slot_q};
      end
      S_L2: begin
        nrn_valid = 1'b1;
        nrn_in1   = z1_q[slot_q[1:0]];
        nrn_in2   = z2_q[slot_q[1:0]];
        nrn_w0    = wrun_q[6];
        nrn_w1    = wrun_q[7];
        nrn_w2    = wrun_q[8];
        issue_tag = '{valid: 1'b1, layer: 1'b1, slot: slot_q};
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

  // Datapath next values: config writes, run snapshot, slot counting, result capture
  always_comb begin
    slot_d   = slot_q;
    wcfg_d   = wcfg_q;
    wrun_d   = wrun_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    z1_d     = z1_q;
    z2_d     = z2_q;
    shadow_d = shadow_q;
    result_d = result_q;

    // The snapshot reads wcfg_q, so a write landing with start misses this run.
    if (state_q == S_IDLE) begin
      if (cfg_we) begin
        for (int i = 0; i < 9; i++) begin
          if (cfg_addr == 4'(i)) wcfg_d[i] = cfg_data;
        end
      end
      if (start) begin
        in1_d  = in1;
        in2_d  = in2;
        wrun_d = wcfg_q;
        slot_d = '0;
      end
    end

    if (state_q == S_L1) begin
      slot_d = slot_q + 3'd1;
    end else if (state_q == S_L2) begin
      slot_d = (slot_q == 3'd3) ? 3'd0 : slot_q + 3'd1;
    end

    if (cap.valid) begin
      if (!cap.layer) begin
        if (cap.slot[0]) z2_d[cap.slot[2:1]] = nrn_result;
        else             z1_d[cap.slot[2:1]] = nrn_result;
      end else begin
        shadow_d[cap.slot[1:0]] = nrn_result;
      end
    end

    // Publish on entry to DONE so result and done become visible together.
    if ((state_q == S_DRAIN2) && (state_d == S_DONE)) result_d = shadow_d;

    tag_d[0] = issue_tag;
    for (int i = 1; i < NLAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Datapath registers; reset drops in-flight tags so stale results are never captured
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      wcfg_q   <= '0;
      wrun_q   <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      z1_q     <= '0;
      z2_q     <= '0;
      shadow_q <= '0;
      result_q <= '0;
      for (int i = 0; i < NLAT; i++) tag_q[i] <= '0;
    end else begin
      slot_q   <= slot_d;
      wcfg_q   <= wcfg_d;
      wrun_q   <= wrun_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      z1_q     <= z1_d;
      z2_q     <= z2_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      for (int i = 0; i < NLAT; i++) tag_q[i] <= tag_d[i];
    end
  end

`ifdef XOR_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Completed-run counter, saturating
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_DONE) && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  // Run counter register
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_runs = perf_q;
`endif

endmodule
